audio_frame_fifo: RTL and testbench

//  Elastic, parametrised multi-channel audio frame buffer between the SIPO deserialiser and the

---
 rtl/audio_pkg.sv | 22 ++
 rtl/fifo_ram.sv | 30 +++
 rtl/audio_frame_fifo.sv | 130 +++++++++++++
 tb/tb_audio_frame_fifo.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module : audio_pkg
// Brief  : Shared types for the audio frame FIFO (FSM states, output modes).
// Rev    : 1.0
// ============================================================================
package audio_pkg;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STREAM = 1'b1
    } fifo_state_e;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_SWAP  = 2'd1,
        MODE_MUTE  = 2'd2,
        MODE_SHIFT = 2'd3
    } audio_mode_e;

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module : fifo_ram
// Brief  : Frame storage, synchronous write, asynchronous read, no reset.
// Rev    : 1.0
// ============================================================================
module fifo_ram #(
    parameter int WORD_W_P = 48,
    parameter int DEPTH_P  = 16
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH_P)-1:0] waddr_i,
    input  logic [WORD_W_P-1:0]        wdata_i,
    input  logic [$clog2(DEPTH_P)-1:0] raddr_i,
    output logic [WORD_W_P-1:0]        rdata_o
);

    logic [WORD_W_P-1:0] r_mem [DEPTH_P];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule
`default_nettype wire

// File: rtl/audio_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module : audio_frame_fifo
// Brief  : Elastic multi-channel audio frame FIFO with prefill, underrun
//          counting and run-time output processing (pass/swap/mute/shift).
// Rev    : 1.0
// ============================================================================
module audio_frame_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH_P   = 24,
    parameter int NUM_CH_P  = 2,
    parameter int DEPTH_P   = 16,
    parameter int PREFILL_P = 8,
    parameter int CNT_W_P   = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          flush_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [NUM_CH_P*WIDTH_P-1:0]   data_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [NUM_CH_P*WIDTH_P-1:0]   data_o,
    input  logic [1:0]                    mode_i,
    input  logic [$clog2(WIDTH_P)-1:0]    shift_i,
    output logic [$clog2(DEPTH_P):0]      count_o,
    output logic [CNT_W_P-1:0]            underrun_o,
    output logic                          streaming_o
);

    localparam int c_addr_w = $clog2(DEPTH_P);
    localparam int c_data_w = NUM_CH_P * WIDTH_P;
    localparam logic [c_addr_w:0] c_prefill = PREFILL_P[c_addr_w:0];

    logic [c_addr_w:0]   r_wr_ptr;
    logic [c_addr_w:0]   r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    fifo_state_e         r_state;
    logic [CNT_W_P-1:0]  r_underrun;

    logic                w_full;
    logic                w_empty;
    logic                w_valid;
    logic                w_push;
    logic                w_pop;
    logic                w_underrun;
    logic [c_data_w-1:0] w_rd_word;
    logic [c_data_w-1:0] w_proc;

    // Wrap bit distinguishes full from empty when the address bits match.
    assign w_full     = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                        (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_valid    = (r_state == STREAM) && !w_empty;
    assign w_push     = valid_i && !w_full;
    assign w_pop      = w_valid && ready_i;
    assign w_underrun = (r_state == STREAM) && w_empty && ready_i;

    fifo_ram #(
        .WORD_W_P (c_data_w),
        .DEPTH_P  (DEPTH_P)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (w_push && !flush_i),
        .waddr_i (r_wr_ptr[c_addr_w-1:0]),
        .wdata_i (data_i),
        .raddr_i (r_rd_ptr[c_addr_w-1:0]),
        .rdata_o (w_rd_word)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_state    <= FILL;
            r_underrun <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= FILL;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            case (r_state)
                FILL: begin
                    if (r_count >= c_prefill) r_state <= STREAM;
                end
                STREAM: begin
                    if (w_underrun) begin
                        r_state <= FILL;
                        if (r_underrun != '1) r_underrun <= r_underrun + 1'b1;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    always_comb begin
        w_proc = '0;
        for (int k = 0; k < NUM_CH_P; k++) begin
            case (audio_mode_e'(mode_i))
                MODE_PASS:  w_proc[k*WIDTH_P +: WIDTH_P] = w_rd_word[k*WIDTH_P +: WIDTH_P];
                MODE_SWAP:  w_proc[k*WIDTH_P +: WIDTH_P] = w_rd_word[(NUM_CH_P-1-k)*WIDTH_P +: WIDTH_P];
                MODE_MUTE:  w_proc[k*WIDTH_P +: WIDTH_P] = '0;
                MODE_SHIFT: w_proc[k*WIDTH_P +: WIDTH_P] =
                                $signed(w_rd_word[k*WIDTH_P +: WIDTH_P]) >>> shift_i;
                default:    w_proc[k*WIDTH_P +: WIDTH_P] = '0;
            endcase
        end
    end

    assign ready_o     = !w_full;
    assign valid_o     = w_valid;
    assign data_o      = w_valid ? w_proc : '0;
    assign count_o     = r_count;
    assign underrun_o  = r_underrun;
    assign streaming_o = (r_state == STREAM);

endmodule
`default_nettype wire

// File: tb/tb_audio_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_audio_frame_fifo
// Brief  : Self-checking bench: queue-based reference model, mode table, corner sequences.
// Rev    : 1.0
// ============================================================================
module tb_audio_frame_fifo;

    localparam int W   = 24;
    localparam int NC  = 2;
    localparam int D   = 16;
    localparam int PF  = 8;
    localparam int CW  = 8;
    localparam int DW  = NC * W;
    localparam int SW  = $clog2(W);
    localparam int CTW = $clog2(D) + 1;
    localparam int UMAX = (1 << CW) - 1;

    logic           clk_i = 1'b0;
    logic           reset_i = 1'b1;
    logic           flush_i = 1'b0;
    logic           valid_i = 1'b0;
    logic           ready_o;
    logic [DW-1:0]  data_i = '0;
    logic           valid_o;
    logic           ready_i = 1'b0;
    logic [DW-1:0]  data_o;
    logic [1:0]     mode_i = 2'd0;
    logic [SW-1:0]  shift_i = '0;
    logic [CTW-1:0] count_o;
    logic [CW-1:0]  underrun_o;
    logic           streaming_o;

    audio_frame_fifo #(
        .WIDTH_P(W), .NUM_CH_P(NC), .DEPTH_P(D), .PREFILL_P(PF), .CNT_W_P(CW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .mode_i(mode_i), .shift_i(shift_i), .count_o(count_o),
        .underrun_o(underrun_o), .streaming_o(streaming_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame queue, streaming flag, underrun tally.
    logic [DW-1:0] q[$];
    bit            m_stream;
    int            m_und;

    typedef struct {
        logic [1:0]    mode;
        int            shift;
        logic [DW-1:0] expect_data;
    } mode_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] process(input logic [DW-1:0] f, input int mode, input int sh);
        logic signed [W-1:0] s [NC];
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < NC; k++) s[k] = f[k*W +: W];
        for (int k = 0; k < NC; k++) begin
            case (mode)
                0:       r[k*W +: W] = s[k];
                1:       r[k*W +: W] = s[NC-1-k];
                2:       r[k*W +: W] = '0;
                default: r[k*W +: W] = s[k] >>> sh;
            endcase
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_frame();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        return v[DW-1:0];
    endfunction

    task automatic check_outputs();
        int occ;
        bit mv;
        occ = q.size();
        mv  = m_stream && (occ > 0);
        check("valid_o", valid_o, mv);
        check("ready_o", ready_o, occ < D);
        check("count_o", count_o, occ);
        check("streaming_o", streaming_o, m_stream);
        check("underrun_o", underrun_o, m_und);
        check("data_o", data_o, mv ? process(q[0], mode_i, shift_i) : '0);
    endtask

    task automatic model_update(input bit v, input bit rd, input logic [DW-1:0] d, input bit fl);
        int occ;
        bit mv, push, pop, und;
        if (fl) begin
            q.delete();
            m_stream = 0;
            return;
        end
        occ  = q.size();
        mv   = m_stream && (occ > 0);
        push = v && (occ < D);
        pop  = mv && rd;
        und  = m_stream && (occ == 0) && rd;
        if (!m_stream) begin
            if (occ >= PF) m_stream = 1;
        end else if (und) begin
            m_stream = 0;
            if (m_und < UMAX) m_und++;
        end
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(d);
    endtask

    // One clock: drive at negedge, check current outputs, then advance the model past the posedge.
    task automatic step(input bit v, input bit rd, input logic [DW-1:0] d, input bit fl);
        @(negedge clk_i);
        valid_i = v; ready_i = rd; data_i = d; flush_i = fl;
        #1;
        check_outputs();
        model_update(v, rd, d, fl);
    endtask

    task automatic model_reset();
        q.delete();
        m_stream = 0;
        m_und    = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        valid_i = 0; ready_i = 0; flush_i = 0;
        reset_i = 1;
        @(negedge clk_i);
        reset_i = 0;
        model_reset();
    endtask

    mode_vec_t mvec [7];

    initial begin
        mvec[0] = '{2'd0, 0,  {24'h000100, 24'hFFF000}};
        mvec[1] = '{2'd1, 0,  {24'hFFF000, 24'h000100}};
        mvec[2] = '{2'd2, 0,  48'h0};
        mvec[3] = '{2'd3, 4,  {24'h000010, 24'hFFFF00}};
        mvec[4] = '{2'd3, 0,  {24'h000100, 24'hFFF000}};
        mvec[5] = '{2'd3, 8,  {24'h000001, 24'hFFFFF0}};
        mvec[6] = '{2'd3, 23, {24'h000000, 24'hFFFFFF}};

        model_reset();
        do_reset();
        step(0, 0, '0, 0);

        // Reset mid-stream with five frames held.
        for (int i = 0; i < PF; i++) step(1, 0, rnd_frame(), 0);
        step(0, 0, '0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, '0, 0);
        @(posedge clk_i);
        #1;
        check("midstream count", count_o, 5);
        reset_i = 1;
        #1;
        check("async rst count", count_o, 0);
        check("async rst valid", valid_o, 0);
        check("async rst ready", ready_o, 1);
        check("async rst streaming", streaming_o, 0);
        check("async rst underrun", underrun_o, 0);
        @(negedge clk_i);
        ready_i = 0;
        @(negedge clk_i);
        reset_i = 0;
        model_reset();
        step(0, 0, '0, 0);

        // Prefill, in-order drain, then a single underrun.
        for (int i = 0; i < PF - 1; i++) step(1, 0, DW'(48'h100 + i), 0);
        step(0, 1, '0, 0);
        check("prefill7 valid", valid_o, 0);
        step(1, 0, DW'(48'h107), 0);
        step(0, 0, '0, 0);
        check("count8 valid still 0", valid_o, 0);
        step(0, 0, '0, 0);
        check("stream valid", valid_o, 1);
        for (int i = 0; i < PF + 1; i++) step(0, 1, '0, 0);
        step(0, 0, '0, 0);
        check("first underrun", underrun_o, 1);
        check("underrun leaves stream", streaming_o, 0);
        for (int i = 0; i < PF - 1; i++) step(1, 1, rnd_frame(), 0);
        step(0, 1, '0, 0);

        // Flush with ten frames held and a simultaneous push.
        for (int i = 0; i < 3; i++) step(1, 0, rnd_frame(), 0);
        step(0, 0, '0, 0);
        step(1, 0, 48'hDEAD_BEEF_0001, 1);
        step(0, 0, '0, 0);
        check("flush count", count_o, 0);
        check("flush streaming", streaming_o, 0);
        check("flush underrun held", underrun_o, 1);
        for (int i = 0; i < PF; i++) step(1, 0, DW'(48'h200 + i), 0);
        for (int i = 0; i < PF + 2; i++) step(0, 1, '0, 0);

        // Full and wrap.
        do_reset();
        for (int i = 0; i < D; i++) step(1, 0, DW'(48'h300 + i), 0);
        step(1, 0, 48'hBAD0_0000_0017, 0);
        check("full ready_o", ready_o, 0);
        check("full count", count_o, D);
        for (int i = 0; i < 40; i++) step(1, 1, DW'(48'h400 + i), 0);
        for (int i = 0; i < D + 2; i++) step(0, 1, '0, 0);

        // Output processing table on a parked frame.
        do_reset();
        mode_i = 2'd0; shift_i = '0;
        for (int i = 0; i < PF; i++) step(1, 0, {24'h000100, 24'hFFF000}, 0);
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        foreach (mvec[i]) begin
            @(negedge clk_i);
            mode_i  = mvec[i].mode;
            shift_i = SW'(mvec[i].shift);
            #1;
            check($sformatf("mode%0d shift%0d", mvec[i].mode, mvec[i].shift), data_o, mvec[i].expect_data);
        end
        mode_i = 2'd0; shift_i = '0;

        // Underrun counter saturation.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < PF; i++) step(1, 0, rnd_frame(), 0);
            for (int i = 0; i < PF + 3; i++) step(0, 1, '0, 0);
        end
        check("underrun saturated", underrun_o, UMAX);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                mode_i  = 2'($urandom_range(0, 3));
                shift_i = SW'($urandom_range(0, W - 1));
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 rnd_frame(), $urandom_range(0, 99) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
